// File: rtl/pipe_addsub_16bit_pkg.sv
// Shared constants and stage payload for the 4-stage pipelined 16-bit adder/subtractor.
// Included by the slice and top modules via import.
package pipe_addsub_16bit_pkg;

  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int NSTAGE = 4;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
  } stage_t;

  function automatic logic [SLICE-1:0] slice_of(
    input logic [WIDTH-1:0] v,
    input int               idx
  );
    return v[idx*SLICE +: SLICE];
  endfunction

endpackage

// File: rtl/pipe_addsub_16bit_slice.sv
// 4-bit carry-lookahead slice: sum and carry out from propagate/generate and carry in.
// One instance serves each pipeline stage.
module addsub_slice_4bit
  import pipe_addsub_16bit_pkg::*;
(
  input  logic [SLICE-1:0] P,
  input  logic [SLICE-1:0] G,
  input  logic             CI,
  output logic [SLICE-1:0] sum,
  output logic             CO
);

  logic [SLICE:0] c;

  always_comb begin
    c[0] = CI;
    c[1] = G[0] | (P[0] & CI);
    c[2] = G[1] | (P[1] & G[0])
         | (P[1] & P[0] & CI);
    c[3] = G[2] | (P[2] & G[1])
         | (P[2] & P[1] & G[0])
         | (P[2] & P[1] & P[0] & CI);
    c[4] = G[3] | (P[3] & G[2])
         | (P[3] & P[2] & G[1])
         | (P[3] & P[2] & P[1] & G[0])
         | (&P & CI);
  end

  assign sum = P ^ c[SLICE-1:0];
  assign CO  = c[SLICE];

endmodule

// File: rtl/pipe_addsub_16bit.sv
// 4-stage pipelined 16-bit add/sub with valid/ready flow control, one 4-bit slice per stage.
// Define PIPE_ADDSUB_OVF_EN to add the signed-overflow output Ofl.
module pipe_addsub_16bit
  import pipe_addsub_16bit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
`ifdef PIPE_ADDSUB_OVF_EN
  output logic             Ofl,
`endif
  output logic             CO
);

  logic             advance;
  logic [WIDTH-1:0] bx;

  stage_t stg_q [NSTAGE];
  stage_t stg_d [NSTAGE];

  logic [SLICE-1:0] sl_a   [NSTAGE];
  logic [SLICE-1:0] sl_b   [NSTAGE];
  logic [SLICE-1:0] sl_sum [NSTAGE];
  logic             sl_ci  [NSTAGE];
  logic             sl_co  [NSTAGE];

  assign advance  = !stg_q[NSTAGE-1].valid || out_ready;
  assign in_ready = advance;

  // Subtract is A + ~B + 1; the +1 enters as carry-in of slice 0.
  assign bx = B ^ {WIDTH{sub}};

  always_comb begin
    sl_a[0]  = slice_of(A, 0);
    sl_b[0]  = slice_of(bx, 0);
    sl_ci[0] = sub;
    for (int i = 1; i < NSTAGE; i++) begin
      sl_a[i]  = slice_of(stg_q[i-1].a_rem, i);
      sl_b[i]  = slice_of(stg_q[i-1].b_rem, i);
      sl_ci[i] = stg_q[i-1].carry;
    end
  end

  for (genvar g = 0; g < NSTAGE; g++) begin : g_slice
    addsub_slice_4bit u_slice (
      .P   (sl_a[g] ^ sl_b[g]),
      .G   (sl_a[g] & sl_b[g]),
      .CI  (sl_ci[g]),
      .sum (sl_sum[g]),
      .CO  (sl_co[g])
    );
  end

  always_comb begin
    stg_d = stg_q;
    if (advance) begin
      stg_d[0].valid              = in_valid;
      stg_d[0].a_rem              = A;
      stg_d[0].b_rem              = bx;
      stg_d[0].sum                = '0;
      stg_d[0].sum[SLICE-1:0]     = sl_sum[0];
      stg_d[0].carry              = sl_co[0];
      for (int i = 1; i < NSTAGE; i++) begin
        stg_d[i]                    = stg_q[i-1];
        stg_d[i].sum[i*SLICE +: SLICE] = sl_sum[i];
        stg_d[i].carry              = sl_co[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_q <= '{default: '0};
    end else begin
      stg_q <= stg_d;
    end
  end

  assign out_valid = stg_q[NSTAGE-1].valid;
  assign S         = stg_q[NSTAGE-1].sum;
  assign CO        = stg_q[NSTAGE-1].carry;

`ifdef PIPE_ADDSUB_OVF_EN
  logic ofl_q;
  logic ofl_d;
  logic msb_ci;

  // Carry into bit 15 recovered from its sum bit and operand bits.
  assign msb_ci = sl_sum[NSTAGE-1][SLICE-1]
                ^ sl_a[NSTAGE-1][SLICE-1]
                ^ sl_b[NSTAGE-1][SLICE-1];

  always_comb begin
    ofl_d = ofl_q;
    if (advance) begin
      ofl_d = msb_ci ^ sl_co[NSTAGE-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ofl_q <= 1'b0;
    end else begin
      ofl_q <= ofl_d;
    end
  end

  assign Ofl = ofl_q;
`endif

endmodule

// File: tb/tb_pipe_addsub_16bit.sv
// Self-checking bench for pipe_addsub_16bit: directed vectors, flow-control
// sequences and randomized traffic against an arithmetic reference model.
module tb_pipe_addsub_16bit;

`ifdef PIPE_ADDSUB_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        co;
  logic        ofl;

  always #5 clk = ~clk;

  pipe_addsub_16bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (s),
`ifdef PIPE_ADDSUB_OVF_EN
    .Ofl       (ofl),
`endif
    .CO        (co)
  );

`ifndef PIPE_ADDSUB_OVF_EN
  assign ofl = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  logic [17:0] sbq [$];
  logic        hold_pend = 1'b0;
  logic [17:0] hold_val;
  logic        last_acc;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ofl;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [17:0] ref_model(input logic [15:0] x,
                                            input logic [15:0] y,
                                            input logic op);
    int          sx;
    int          sy;
    int          r;
    logic [15:0] rs;
    logic        rc;
    logic        ro;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (op) begin
      rs = x - y;
      rc = (x >= y);
      r  = sx - sy;
    end else begin
      rs = x + y;
      rc = (32'(x) + 32'(y)) > 32'h0000_FFFF;
      r  = sx + sy;
    end
    ro = (r > 32767) || (r < -32768);
    return {rs, rc, ro & OVF};
  endfunction

  task automatic step(input logic v, input logic [15:0] x,
                      input logic [15:0] y, input logic op,
                      input logic ordy);
    @(negedge clk);
    in_valid  = v;
    a         = x;
    b         = y;
    sub       = op;
    out_ready = ordy;
    #1;
    if (hold_pend)
      check("hold", 32'({out_valid, s, co, ofl}), 32'({1'b1, hold_val}));
    check("in_ready_rule", 32'(in_ready), 32'(!out_valid || ordy));
    if (out_valid && ordy) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got %h expected none", {s, co, ofl});
      end else begin
        check("result", 32'({s, co, ofl}), 32'(sbq.pop_front()));
      end
    end
    last_acc = v && in_ready;
    if (last_acc) sbq.push_back(ref_model(x, y, op));
    hold_pend = out_valid && !ordy;
    hold_val  = {s, co, ofl};
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (sbq.size() == 0 && !out_valid) break;
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    end
    check("drain_empty", 32'(sbq.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    sbq.delete();
    hold_pend = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[1] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[2] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vt[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[4] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vt[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[6] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0};
    vt[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[8] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vt[9] = '{16'h5555, 16'hAAAA, 1'b1, 16'hAAAB, 1'b0, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", 32'({out_valid, s, co, ofl}), 32'd0);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors, one at a time, with exact latency check.
    foreach (vt[i]) begin
      @(negedge clk);
      in_valid  = 1'b1;
      a         = vt[i].a;
      b         = vt[i].b;
      sub       = vt[i].sub;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d_early", i), 32'(out_valid), 32'd0);
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'({out_valid, s, co, ofl}),
            32'({1'b1, vt[i].s, vt[i].co, vt[i].ofl & OVF}));
    end
    repeat (2) @(negedge clk);

    // Back-to-back beats drain on consecutive cycles.
    for (int i = 0; i < 8; i++) begin
      step(i < 4, 16'(16'h1111 * (i + 1)), 16'(16'h0F00 + i), 1'(i & 1), 1'b1);
      if (i < 4) check("b2b_in_ready", 32'(in_ready), 32'd1);
      if (i >= 4) check("b2b_out_valid", 32'(out_valid), 32'd1);
    end
    drain(10);

    // Full pipe stalled for 3 cycles, then released.
    for (int i = 0; i < 4; i++)
      step(1'b1, 16'(16'hA000 + i), 16'(16'h1234 * i), 1'(i & 1), 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    drain(12);

    // Reset with 3 beats in flight: none emerge afterwards.
    for (int i = 0; i < 3; i++)
      step(1'b1, 16'(16'h0100 + i), 16'h0001, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      check("post_reset_idle", 32'(out_valid), 32'd0);
    end
    step(1'b1, 16'h4000, 16'h4000, 1'b0, 1'b1);
    step(1'b1, 16'h0010, 16'h0020, 1'b1, 1'b1);
    drain(12);

    // Randomized traffic with random backpressure.
    begin
      int issued;
      int cyc;
      issued = 0;
      cyc    = 0;
      while (issued < 10000 && cyc < 60000) begin
        step(($urandom % 4) != 0, 16'($urandom), 16'($urandom),
             1'($urandom), ($urandom % 4) != 0);
        if (last_acc) issued++;
        cyc++;
      end
      check("rand_issued", 32'(issued), 32'd10000);
    end
    drain(50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
